kmc_nprx: RTL and testbench
===========================

KMC_NPRX -- requirements
Module: kmc_nprx

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 kmcINIT  input  1  KMC initialize, synchronous, same effect as rst.
REQ-004 nprREQI  input  1  NPR request from NPR control register bit 0; held high until acknowledge or NXM timeout.
REQ-005 nprACKO  output  1  NPR acknowledge to NPR control; single-cycle pulse.
REQ-006 kmcNPRC  input  8  NPR control register: [7] byte xfer, [4] NPR out, [3:2] input bus address extension.
REQ-007 kmcIBA  input  16  input bus address (NPR in).
REQ-008 kmcOBA  input  16  output bus address (NPR out).
REQ-009 kmcBAEO  input  2  output bus address extension, bits 17:16.
REQ-010 kmcODATA  input  16  output data for NPR out.
REQ-011 kmcIDATA  output  16  input data captured on NPR in.
REQ-012 busREQO  output  1  bus cycle request to KS10 bus arbiter.
REQ-013 busACKI  input  1  bus cycle acknowledge; busDATAI valid in the same cycle.
REQ-014 busADDRO  output  36  bus address word: [35:22]=0, [21] IO, [20] BYTE, [19] WRITE, [18] READ, [17:0] Unibus address.
REQ-015 busDATAO  output  36  write data: {20'b0, data[15:0]}.
REQ-016 busDATAI  input  36  read data; only [15:0] used.

Function
REQ-017 The block SHALL implement states IDLE, REQ, ACK, WAIT.
REQ-018 IDLE: when nprREQI=1, the block SHALL latch direction (NPRC[4]), byte (NPRC[7]), address, and write data, then enter REQ the next cycle.
REQ-019 Latched address SHALL be {kmcBAEO,kmcOBA} when NPRC[4]=1, else {kmcNPRC[3:2],kmcIBA}.
REQ-020 REQ: busREQO SHALL be 1, busADDRO SHALL present IO=1, BYTE=latched byte, WRITE=NPRO, READ=~NPRO, plus the latched address; busDATAO SHALL present latched kmcODATA on writes and 0 on reads.
REQ-021 Byte writes SHALL drive kmcODATA unmodified; address bit 0 selects the lane.
REQ-022 REQ with busACKI=1: on reads, kmcIDATA SHALL load busDATAI[15:0] that cycle; then enter ACK and drop busREQO.
REQ-023 ACK: nprACKO SHALL be 1 for exactly one cycle; then enter WAIT.
REQ-024 WAIT: the block SHALL remain until nprREQI=0, then enter IDLE; no new transfer is started while nprREQI stays high.
REQ-025 Request-to-bus latency SHALL be exactly 1 cycle (nprREQI rise -> busREQO high next cycle); busACKI -> nprACKO SHALL be exactly 1 cycle.
REQ-026 REQ with nprREQI=0 (NXM timeout upstream) SHALL abort: busREQO drops next cycle, no nprACKO, kmcIDATA unchanged, return to IDLE.
REQ-027 If busACKI and nprREQI=0 occur in the same REQ cycle, busACKI SHALL win (data captured, ACK pulse issued).
REQ-028 busACKI outside REQ SHALL be ignored.
REQ-029 Input changes after the latch cycle SHALL NOT alter the cycle in progress.
REQ-030 kmcIDATA SHALL hold its value until the next completed read; writes leave it unchanged.

Reset
REQ-031 rst or kmcINIT SHALL force state IDLE, busREQO=0, nprACKO=0, kmcIDATA=0, busADDRO=0, busDATAO=0, latched fields=0, effective next edge.
REQ-032 Reset mid-cycle (REQ or ACK) SHALL abandon the transfer with no acknowledge pulse.

Structure
REQ-033 State encoding and busADDRO flag bit positions (IO, BYTE, WRITE, READ) SHALL be defined once in the shared KMC package, not locally.
REQ-034 The block SHALL be a single module with no sub-modules; all outputs registered.

Verification
REQ-035 Word read: NPRC=8'h0D, IBA=16'o1000, busACKI after 3 cycles with busDATAI=36'o123456 -> busADDRO has READ=1, addr=18'o601000; kmcIDATA=16'o123456; one nprACKO pulse.
REQ-036 Byte write: NPRC=8'h91, OBA=16'o2001, BAEO=2'b10, ODATA=16'h00A5 -> busADDRO WRITE=1, BYTE=1, addr=18'o402001, busDATAO=36'h000A5.
REQ-037 Abort: nprREQI high, no busACKI, nprREQI drops after 100 cycles -> busREQO low next cycle, no nprACKO, kmcIDATA unchanged.
REQ-038 Held request: nprREQI stays high 5 cycles after nprACKO -> exactly one bus cycle; new nprREQI rise starts a second.
REQ-039 Simultaneous busACKI and nprREQI fall in REQ -> data captured and nprACKO pulsed.
REQ-040 kmcINIT asserted in REQ -> all outputs zero next cycle; later nprREQI starts a clean transfer.

Source files
------------

// File: rtl/kmc_nprx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kmc_nprx_pkg
//  Purpose  : Shared KMC definitions for the NPR bus-cycle engine: state
//             encoding, KS10 bus address word flag positions, NPR control
//             register bit positions and a helper that packs an address word.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package kmc_nprx_pkg;

    // NPR engine states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_WAIT = 2'd3
    } nprState_t;

    // Flag bit positions in the 36-bit KS10 bus address word.
    localparam int c_ADDR_IO    = 21;
    localparam int c_ADDR_BYTE  = 20;
    localparam int c_ADDR_WRITE = 19;
    localparam int c_ADDR_READ  = 18;

    // NPR control register fields.
    localparam int c_NPRC_BYTE  = 7;
    localparam int c_NPRC_OUT   = 4;

    // Widths.
    localparam int c_BUS_W      = 36;
    localparam int c_UBA_W      = 18;
    localparam int c_DATA_W     = 16;

    // Build a bus address word for an IO-space NPR cycle. READ is always
    // the complement of WRITE for NPR transfers.
    function automatic logic [c_BUS_W-1:0] busAddrWord(
        input logic               byteXfer,
        input logic               write,
        input logic [c_UBA_W-1:0] addr
    );
        logic [c_BUS_W-1:0] word;
        word                = '0;
        word[c_UBA_W-1:0]   = addr;
        word[c_ADDR_IO]     = 1'b1;
        word[c_ADDR_BYTE]   = byteXfer;
        word[c_ADDR_WRITE]  = write;
        word[c_ADDR_READ]   = ~write;
        return word;
    endfunction

endpackage : kmc_nprx_pkg
`default_nettype wire

// File: rtl/kmc_nprx_if.sv
`default_nettype none
// ============================================================================
//  Module   : kmc_nprx_if
//  Purpose  : Bundles the NPR control handshake, KMC register inputs and the
//             KS10 bus request/acknowledge/data signals of the NPR engine.
//  Ports    : master - drives requests/registers/bus responses (environment)
//             slave  - the NPR engine (kmc_nprx)
//  Revision : 1.0  initial release
// ============================================================================
interface kmc_nprx_if;

    // NPR control side
    logic        kmcINIT;
    logic        nprREQI;
    logic        nprACKO;
    logic [7:0]  kmcNPRC;
    logic [15:0] kmcIBA;
    logic [15:0] kmcOBA;
    logic [1:0]  kmcBAEO;
    logic [15:0] kmcODATA;
    logic [15:0] kmcIDATA;

    // KS10 bus side
    logic        busREQO;
    logic        busACKI;
    logic [35:0] busADDRO;
    logic [35:0] busDATAO;
    logic [35:0] busDATAI;

    modport master (
        output kmcINIT, nprREQI, kmcNPRC, kmcIBA, kmcOBA, kmcBAEO, kmcODATA,
               busACKI, busDATAI,
        input  nprACKO, kmcIDATA, busREQO, busADDRO, busDATAO
    );

    modport slave (
        input  kmcINIT, nprREQI, kmcNPRC, kmcIBA, kmcOBA, kmcBAEO, kmcODATA,
               busACKI, busDATAI,
        output nprACKO, kmcIDATA, busREQO, busADDRO, busDATAO
    );

endinterface : kmc_nprx_if
`default_nettype wire

// File: rtl/kmc_nprx.sv
`default_nettype none
// ============================================================================
//  Module   : kmc_nprx
//  Purpose  : KMC NPR (non-processor request) bus-cycle engine. Latches a
//             transfer request from the NPR control register, runs one KS10
//             bus cycle (read into kmcIDATA or write from kmcODATA), returns a
//             single-cycle acknowledge, then waits for the request to drop.
//             An upstream NXM timeout (request dropped before bus acknowledge)
//             abandons the cycle silently.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - kmc_nprx_if.slave: NPR control handshake, KMC register
//                    inputs, bus request/address/data, captured read data
//  Revision : 1.0  initial release
// ============================================================================
module kmc_nprx
    import kmc_nprx_pkg::*;
(
    input wire          clk,
    input wire          rst,
    kmc_nprx_if.slave   bus
);

    nprState_t              r_state;
    nprState_t              w_stateNext;

    logic                   w_clear;
    logic                   w_latch;
    logic                   w_done;
    logic                   w_abort;
    logic [c_UBA_W-1:0]     w_latchAddr;
    logic                   w_latchOut;
    logic                   w_latchByte;

    logic                   r_nprOut;
    logic                   r_busReq;
    logic [c_BUS_W-1:0]     r_busAddr;
    logic [c_BUS_W-1:0]     r_busData;
    logic                   r_ack;
    logic [c_DATA_W-1:0]    r_iData;

    // Bits of the register/bus inputs that this engine never looks at.
    logic                   w_unusedBits;
    assign w_unusedBits = ^{bus.busDATAI[35:16], bus.kmcNPRC[6:5],
                            bus.kmcNPRC[1:0]};

    // KMC initialize behaves exactly like a system reset.
    assign w_clear     = rst | bus.kmcINIT;

    assign w_latchOut  = bus.kmcNPRC[c_NPRC_OUT];
    assign w_latchByte = bus.kmcNPRC[c_NPRC_BYTE];
    assign w_latchAddr = w_latchOut ? {bus.kmcBAEO, bus.kmcOBA}
                                    : {bus.kmcNPRC[3:2], bus.kmcIBA};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_latch     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.nprREQI) begin
                    w_latch     = 1'b1;
                    w_stateNext = ST_REQ;
                end
            end
            ST_REQ: begin
                // A bus acknowledge beats a simultaneous request drop.
                if (bus.busACKI) begin
                    w_done      = 1'b1;
                    w_stateNext = ST_ACK;
                end else if (!bus.nprREQI) begin
                    w_abort     = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            ST_ACK: begin
                w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                // Hold off until the requester releases, so a request that
                // stays high never starts a second transfer.
                if (!bus.nprREQI) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs. The bus address/data registers
    // double as the latched transfer fields, so later register changes
    // cannot disturb a cycle in progress.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_nprOut  <= 1'b0;
            r_busReq  <= 1'b0;
            r_busAddr <= '0;
            r_busData <= '0;
            r_ack     <= 1'b0;
            r_iData   <= '0;
        end else begin
            r_ack <= w_done;

            if (w_latch) begin
                r_nprOut  <= w_latchOut;
                r_busReq  <= 1'b1;
                r_busAddr <= busAddrWord(w_latchByte, w_latchOut, w_latchAddr);
                // Byte writes pass the word through; the bus picks the lane
                // from address bit 0.
                r_busData <= w_latchOut ? {20'b0, bus.kmcODATA} : '0;
            end

            if (w_done || w_abort) begin
                r_busReq  <= 1'b0;
                r_busAddr <= '0;
                r_busData <= '0;
            end

            if (w_done && !r_nprOut) begin
                r_iData <= bus.busDATAI[c_DATA_W-1:0];
            end
        end
    end

    assign bus.busREQO  = r_busReq;
    assign bus.busADDRO = r_busAddr;
    assign bus.busDATAO = r_busData;
    assign bus.nprACKO  = r_ack;
    assign bus.kmcIDATA = r_iData;

endmodule : kmc_nprx
`default_nettype wire

// File: tb/tb_kmc_nprx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kmc_nprx
//  Purpose  : Self-checking bench for kmc_nprx. Stimulus pushes expected bus
//             cycles and acknowledge data into queues; a monitor pops and
//             compares them whenever the DUT starts a bus cycle or pulses
//             nprACKO.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_kmc_nprx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    kmc_nprx_if bus();

    kmc_nprx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [35:0] addr;
        logic [35:0] data;
    } busExp_t;

    busExp_t     qBus[$];
    logic [15:0] qAck[$];
    busExp_t     mBus;
    logic [15:0] mIData;
    logic        prevReq = 1'b0;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [35:0] act,
                         input logic [35:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares each new bus cycle and each acknowledge pulse
    // against the oldest queued expectation.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (bus.busREQO && !prevReq) begin
            if (qBus.size() == 0) begin
                check("unexpected busREQO", {35'b0, bus.busREQO}, 36'd0);
            end else begin
                mBus = qBus.pop_front();
                check("mon busADDRO", bus.busADDRO, mBus.addr);
                check("mon busDATAO", bus.busDATAO, mBus.data);
            end
        end
        if (bus.nprACKO) begin
            if (qAck.size() == 0) begin
                check("unexpected nprACKO", {35'b0, bus.nprACKO}, 36'd0);
            end else begin
                mIData = qAck.pop_front();
                check("mon kmcIDATA", {20'b0, bus.kmcIDATA}, {20'b0, mIData});
            end
        end
        prevReq <= bus.busREQO;
    end

    // One complete NPR transfer. Called at a negedge; returns at a negedge.
    task automatic doXfer(input string tag, input logic [7:0] nprc,
                          input logic [15:0] iba, input logic [15:0] oba,
                          input logic [1:0] baeo, input logic [15:0] odata,
                          input logic [35:0] busData, input int ackDelay,
                          input int hold, input logic [35:0] expAddr,
                          input logic [35:0] expData, input logic [15:0] expIData,
                          input bit simulDrop);
        qBus.push_back('{expAddr, expData});
        qAck.push_back(expIData);
        bus.kmcNPRC  = nprc;
        bus.kmcIBA   = iba;
        bus.kmcOBA   = oba;
        bus.kmcBAEO  = baeo;
        bus.kmcODATA = odata;
        bus.nprREQI  = 1'b1;
        @(negedge clk);
        check({tag, " req latency"}, {35'b0, bus.busREQO}, 36'd1);
        // Scramble the register inputs; the cycle must not notice.
        bus.kmcNPRC  = ~nprc;
        bus.kmcIBA   = ~iba;
        bus.kmcOBA   = ~oba;
        bus.kmcBAEO  = ~baeo;
        bus.kmcODATA = ~odata;
        repeat (ackDelay) @(negedge clk);
        check({tag, " addr held"}, bus.busADDRO, expAddr);
        check({tag, " data held"}, bus.busDATAO, expData);
        bus.busACKI  = 1'b1;
        bus.busDATAI = busData;
        if (simulDrop) bus.nprREQI = 1'b0;
        @(negedge clk);
        bus.busACKI  = 1'b0;
        bus.busDATAI = 36'hF_FFFF_FFFF;
        check({tag, " ack pulse"}, {35'b0, bus.nprACKO}, 36'd1);
        check({tag, " req dropped"}, {35'b0, bus.busREQO}, 36'd0);
        @(negedge clk);
        check({tag, " ack single"}, {35'b0, bus.nprACKO}, 36'd0);
        repeat (hold) @(negedge clk);
        check({tag, " no retrigger"}, {35'b0, bus.busREQO}, 36'd0);
        bus.nprREQI = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.kmcINIT  = 1'b0;
        bus.nprREQI  = 1'b0;
        bus.kmcNPRC  = 8'h00;
        bus.kmcIBA   = 16'h0000;
        bus.kmcOBA   = 16'h0000;
        bus.kmcBAEO  = 2'b00;
        bus.kmcODATA = 16'h0000;
        bus.busACKI  = 1'b0;
        bus.busDATAI = 36'h0;
        repeat (3) @(negedge clk);
        check("reset busREQO",  {35'b0, bus.busREQO}, 36'd0);
        check("reset nprACKO",  {35'b0, bus.nprACKO}, 36'd0);
        check("reset busADDRO", bus.busADDRO, 36'd0);
        check("reset busDATAO", bus.busDATAO, 36'd0);
        check("reset kmcIDATA", {20'b0, bus.kmcIDATA}, 36'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word read: addr 18'o601000, READ|IO, data 16'o123456.
        doXfer("rd", 8'h0D, 16'o1000, 16'h0000, 2'b00, 16'h0000, 36'o123456,
               3, 0, 36'h0_0027_0200, 36'h0, 16'hA72E, 1'b0);

        // Stray bus acknowledge while idle is ignored.
        bus.busACKI  = 1'b1;
        bus.busDATAI = 36'h0_0000_5555;
        @(negedge clk);
        bus.busACKI  = 1'b0;
        @(negedge clk);
        check("stray ack idata", {20'b0, bus.kmcIDATA}, 36'h0_0000_A72E);
        check("stray ack busREQO", {35'b0, bus.busREQO}, 36'd0);

        // Byte write with request held 5 cycles after acknowledge.
        doXfer("bw", 8'h91, 16'h0000, 16'o2001, 2'b10, 16'h00A5, 36'h0_0000_FFFF,
               1, 5, 36'h0_003A_0401, 36'h0_0000_00A5, 16'hA72E, 1'b0);

        // Abort: no bus acknowledge, request dropped after ~100 cycles.
        qBus.push_back('{36'h0_0025_0010, 36'h0});
        bus.kmcNPRC = 8'h04;
        bus.kmcIBA  = 16'h0010;
        bus.nprREQI = 1'b1;
        @(negedge clk);
        check("abort req", {35'b0, bus.busREQO}, 36'd1);
        repeat (99) @(negedge clk);
        bus.nprREQI = 1'b0;
        @(negedge clk);
        check("abort req drop", {35'b0, bus.busREQO}, 36'd0);
        check("abort no ack", {35'b0, bus.nprACKO}, 36'd0);
        check("abort addr clr", bus.busADDRO, 36'd0);
        check("abort idata", {20'b0, bus.kmcIDATA}, 36'h0_0000_A72E);
        repeat (3) @(negedge clk);

        // Bus acknowledge and request drop in the same cycle: ack wins.
        doXfer("sim", 8'h00, 16'h0100, 16'h0000, 2'b00, 16'h0000, 36'h0_0000_1234,
               2, 0, 36'h0_0024_0100, 36'h0, 16'h1234, 1'b1);

        // KMC initialize in the middle of a bus cycle.
        qBus.push_back('{36'h0_0027_0002, 36'h0});
        bus.kmcNPRC = 8'h0C;
        bus.kmcIBA  = 16'h0002;
        bus.nprREQI = 1'b1;
        @(negedge clk);
        bus.kmcINIT = 1'b1;
        @(negedge clk);
        check("init busREQO",  {35'b0, bus.busREQO}, 36'd0);
        check("init nprACKO",  {35'b0, bus.nprACKO}, 36'd0);
        check("init busADDRO", bus.busADDRO, 36'd0);
        check("init busDATAO", bus.busDATAO, 36'd0);
        check("init kmcIDATA", {20'b0, bus.kmcIDATA}, 36'd0);
        bus.kmcINIT = 1'b0;
        bus.nprREQI = 1'b0;
        repeat (3) @(negedge clk);

        // Clean word write after initialize.
        doXfer("wr", 8'h10, 16'h0000, 16'h1234, 2'b01, 16'hBEEF, 36'h0_0000_0000,
               1, 0, 36'h0_0029_1234, 36'h0_0000_BEEF, 16'h0000, 1'b0);

        repeat (2) @(negedge clk);
        check("bus queue drained", 36'(qBus.size()), 36'd0);
        check("ack queue drained", 36'(qAck.size()), 36'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_kmc_nprx
`default_nettype wire
